// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART TX scheduler.
//   uart_state_t : frame FSM states
//   UART_FRAME_BITS, UART_IDLE_LVL : 8N1 framing constants
//   rr_pick      : rotating-priority winner selection (up to 8 requesters)
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int   UART_FRAME_BITS = 10;   // start + 8 data + stop
  localparam logic UART_IDLE_LVL   = 1'b1;
  localparam int   RR_MAX          = 8;

  // First valid index searched from (last+1) mod n upward, wrapping.
  // Scanning from the farthest candidate down lets the nearest one win last.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] last,
                                         input int         n);
    logic [2:0] win;
    logic [2:0] idx;
    win = last;
    for (int i = RR_MAX; i >= 1; i--) begin
      if (i <= n) begin
        idx = 3'((int'(last) + i) % n);
        if (valid[idx]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake bundle of the UART TX scheduler.
//   req_valid : per-requester byte pending
//   req_data  : byte of requester i at [DATA_W*i +: DATA_W]
//   req_ready : one-hot accept strobe from the scheduler
// master = byte producers, slave = scheduler.
interface uart_tx_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler_serializer.sv
// 8N1 frame serializer: IDLE -> START -> DATA -> STOP -> IDLE.
//   clk, reset : clock, asynchronous active-low reset
//   load       : accept byte_in (honoured only in IDLE)
//   byte_in    : payload, sent LSB first
//   tx         : serial line, idle high
//   done       : high while no frame is in flight (line free for a new load)
module uart_tx_serializer
  import uart_tx_scheduler_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] byte_in,
  output logic              tx,
  output logic              done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_FRAME_BITS - 3);

  uart_state_t       state, state_nxt;
  logic [TW-1:0]     tick;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              bit_end;

  assign bit_end = (tick == TICK_LAST);
  assign done    = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx        = UART_IDLE_LVL;
    unique case (state)
      IDLE:  if (load) state_nxt = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end && bit_cnt == BIT_LAST) state_nxt = STOP;
      end
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-time counter restarts on every state change so each bit is exactly
  // CLKS_PER_BIT cycles and no error accumulates across the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick    <= '0;
      bit_cnt <= '0;
    end else begin
      if (state != state_nxt || state == IDLE || bit_end) tick <= '0;
      else                                                tick <= tick + 1'b1;
      if (state != DATA)  bit_cnt <= '0;
      else if (bit_end)   bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Payload register carries no reset; it is only observed after a load.
  always_ff @(posedge clk) begin
    if (state == IDLE && load)        shift_reg <= byte_in;
    else if (state == DATA && bit_end) shift_reg <= shift_reg >> 1;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART TX line among N_REQ producers.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : req_valid / req_data / req_ready handshake (slave side)
//   tx         : serial line, idle high
//   busy       : high from the cycle after accept through the last stop cycle
//   grant_id   : index of the last accepted requester
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_tx_scheduler_if.slave       bus,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);

  logic [7:0]        valid8;
  logic [2:0]        last_grant;
  logic [2:0]        pick;
  logic              idle;
  logic              accept;
  logic [DATA_W-1:0] pick_data;

  always_comb begin
    valid8             = '0;
    valid8[N_REQ-1:0]  = bus.req_valid;
  end

  assign pick = rr_pick(valid8, last_grant, N_REQ);

  // Gated by reset so no handshake can complete while reset is held.
  assign accept = idle && reset && (|bus.req_valid);
  assign busy   = !idle;

  always_comb begin
    bus.req_ready = '0;
    pick_data     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = accept && (pick == 3'(i));
      if (pick == 3'(i)) pick_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Pointer resets to the last index so requester 0 has first priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 3'(N_REQ - 1);
      grant_id   <= '0;
    end else if (accept) begin
      last_grant <= pick;
      grant_id   <= GW'(pick);
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .byte_in (pick_data),
    .tx      (tx),
    .done    (idle)
  );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler (N_REQ=4, CLKS_PER_BIT=10).
// Stimulus pushes expected accepts and expected frame bytes; two monitors
// (handshake and serial-line decoder) pop and compare.
module tb_uart_tx_scheduler;

  localparam int N_REQ = 4;
  localparam int CPB   = 10;
  localparam int DW    = 8;

  typedef struct {
    int id;
    int gap;   // required cycles since previous accept, 0 = don't care
  } acc_t;

  logic       clk;
  logic       reset;
  logic       tx;
  logic       busy;
  logic [1:0] grant_id;

  uart_tx_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DW)) bus ();

  uart_tx_scheduler #(.N_REQ(N_REQ), .CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  acc_t       acc_q[$];
  logic [7:0] frm_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic push_acc(input int id, input int gap);
    acc_t e;
    e.id  = id;
    e.gap = gap;
    acc_q.push_back(e);
  endtask

  // Handshake monitor
  int   cyc_n    = 0;
  int   last_acc = 0;
  logic gid_pend = 1'b0;
  int   gid_exp  = 0;
  always @(negedge clk) begin
    acc_t e;
    cyc_n++;
    if (!reset) begin
      gid_pend = 1'b0;
    end else begin
      if (gid_pend) begin
        chk("grant_id", 32'(grant_id), 32'(gid_exp));
        gid_pend = 1'b0;
      end
      if ((bus.req_valid & bus.req_ready) != '0) begin
        if (acc_q.size() == 0) begin
          chk("accept_unexpected", 32'(bus.req_ready), 32'h0);
        end else begin
          e = acc_q.pop_front();
          chk("accept_ready", 32'(bus.req_ready), 32'(1 << e.id));
          if (e.gap != 0) chk("accept_gap", 32'(cyc_n - last_acc), 32'(e.gap));
          last_acc = cyc_n;
          gid_pend = 1'b1;
          gid_exp  = e.id;
        end
      end
    end
  end

  // Serial-line decoder: every cycle of each bit must hold the bit's level.
  logic       in_frame = 1'b0;
  logic       prev_tx  = 1'b1;
  logic       glitch   = 1'b0;
  logic [9:0] bits     = '0;
  int         fcyc     = 0;
  always @(negedge clk) begin
    logic [7:0] exp_b;
    int bi;
    if (!reset) begin
      in_frame = 1'b0;
      prev_tx  = 1'b1;
    end else begin
      if (!in_frame && prev_tx && !tx) begin
        in_frame = 1'b1;
        fcyc     = 0;
        glitch   = 1'b0;
      end
      if (in_frame) begin
        bi = fcyc / CPB;
        if (fcyc % CPB == 0) bits[bi] = tx;
        else if (tx !== bits[bi]) glitch = 1'b1;
        fcyc++;
        if (fcyc == 10 * CPB) begin
          in_frame = 1'b0;
          if (frm_q.size() == 0) begin
            chk("frame_unexpected", {22'h0, bits}, 32'h0);
          end else begin
            exp_b = frm_q.pop_front();
            chk("frame", {21'h0, glitch, bits[9], bits[0], bits[8:1]},
                {21'h0, 1'b0, 1'b1, 1'b0, exp_b});
          end
        end
      end
      prev_tx = tx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // 1: reset values, then a single A5 frame
    tick(2);
    bus.req_valid = 4'b0001;
    #1;
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    bus.req_valid = '0;
    reset = 1'b1;
    tick(1);
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'hA5;
    push_acc(0, 0);
    frm_q.push_back(8'hA5);
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    tick(1);
    bus.req_valid = '0;
    chk("t1_busy_start", 32'(busy), 32'h1);
    chk("t1_tx_start", 32'(tx), 32'h0);
    tick(105);
    chk("t1_busy_after", 32'(busy), 32'h0);
    chk("t1_tx_after", 32'(tx), 32'h1);

    // 2: all four valid, rotation 0,1,2,3,0 at 101-cycle spacing
    do_reset();
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*8 +: 8] = 8'h10 + 8'(i);
    bus.req_valid = 4'b1111;
    push_acc(0, 0);
    push_acc(1, 101);
    push_acc(2, 101);
    push_acc(3, 101);
    push_acc(0, 101);
    frm_q.push_back(8'h10);
    frm_q.push_back(8'h11);
    frm_q.push_back(8'h12);
    frm_q.push_back(8'h13);
    frm_q.push_back(8'h10);
    tick(1);
    tick(404);
    bus.req_valid = '0;
    tick(110);

    // 3: single requester 2 held, frames back to back
    do_reset();
    bus.req_data[23:16] = 8'h3C;
    bus.req_valid = 4'b0100;
    push_acc(2, 0);
    push_acc(2, 101);
    push_acc(2, 101);
    repeat (3) frm_q.push_back(8'h3C);
    tick(1);
    tick(202);
    bus.req_valid = '0;
    tick(110);

    // 4: reset mid-frame, pointer returns to favour requester 0 side
    do_reset();
    bus.req_data[23:16] = 8'h77;
    bus.req_valid = 4'b0100;
    push_acc(2, 0);
    tick(1);
    bus.req_valid = '0;
    tick(34);
    bus.req_data[15:8]  = 8'h21;
    bus.req_data[31:24] = 8'h23;
    bus.req_valid = 4'b1010;
    reset = 1'b0;
    #1;
    chk("t4_rst_tx", 32'(tx), 32'h1);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_ready", 32'(bus.req_ready), 32'h0);
    tick(2);
    push_acc(1, 0);
    push_acc(3, 101);
    frm_q.push_back(8'h21);
    frm_q.push_back(8'h23);
    reset = 1'b1;
    tick(1);
    bus.req_valid[1] = 1'b0;
    tick(101);
    bus.req_valid[3] = 1'b0;
    tick(110);

    // 5: one-cycle pulse on requester 3 while busy is never accepted
    do_reset();
    bus.req_data[7:0] = 8'h81;
    bus.req_valid = 4'b0001;
    push_acc(0, 0);
    frm_q.push_back(8'h81);
    tick(1);
    bus.req_valid = '0;
    tick(20);
    bus.req_data[31:24] = 8'h99;
    bus.req_valid = 4'b1000;
    tick(1);
    bus.req_valid = '0;
    tick(120);
    chk("t5_busy_idle", 32'(busy), 32'h0);
    chk("t5_tx_idle", 32'(tx), 32'h1);
    chk("t5_no_pending", 32'(acc_q.size()), 32'h0);

    // 6: source data changes mid-frame; latched byte is sent
    do_reset();
    bus.req_data[7:0] = 8'h5A;
    bus.req_valid = 4'b0001;
    push_acc(0, 0);
    frm_q.push_back(8'h5A);
    tick(1);
    bus.req_valid = '0;
    tick(30);
    bus.req_data[7:0] = 8'hFF;
    tick(90);

    tick(20);
    chk("acc_q_empty", 32'(acc_q.size()), 32'h0);
    chk("frm_q_empty", 32'(frm_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
